// File: rtl/alpaca_phasor_gen_if.sv
// Phasor generator stream interface.
// Carries the per-sample request (vld_in) towards the generator and the
// resulting phasor (br/bi), its debug index and the valid/last strobes back.
//   master : sample source / phasor consumer (drives vld_in)
//   slave  : phasor generator (drives br, bi, vld_out, last_out, idx_out)
interface alpaca_phasor_gen_if #(
  parameter int unsigned M           = 8,
  parameter int unsigned PHASE_WIDTH = 16
);
  localparam int unsigned IdxWidth = $clog2(M);

  logic                   vld_in;
  logic [PHASE_WIDTH-1:0] br;
  logic [PHASE_WIDTH-1:0] bi;
  logic                   vld_out;
  logic                   last_out;
  logic [IdxWidth-1:0]    idx_out;

  modport master (
    output vld_in,
    input  br,
    input  bi,
    input  vld_out,
    input  last_out,
    input  idx_out
  );

  modport slave (
    input  vld_in,
    output br,
    output bi,
    output vld_out,
    output last_out,
    output idx_out
  );
endinterface

// File: rtl/alpaca_phasor_gen.sv
// Streaming twiddle generator: W = exp(-j*2*pi*k*n*D/M) for bin k of frame n.
// The phase index is built incrementally (no multiplier) and looked up in a
// cos/-sin ROM filled at elaboration. Output latency is fixed at 2 cycles.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : slave side of alpaca_phasor_gen_if
//          vld_in            - one sample slot this cycle, advances counters
//          br / bi           - signed (PHASE_WIDTH, PHASE_FRAC_WIDTH) phasor
//          vld_out, last_out - vld_in delayed 2 cycles; last marks k = M-1
//          idx_out           - phase index of the current br/bi
module alpaca_phasor_gen #(
  parameter int unsigned M                = 8,
  parameter int unsigned D                = 6,
  parameter int unsigned PHASE_WIDTH      = 16,
  parameter int unsigned PHASE_FRAC_WIDTH = 15
) (
  input  logic                clk,
  input  logic                rst,
  alpaca_phasor_gen_if.slave  bus
);

  localparam int unsigned IdxWidth = $clog2(M);
  localparam int unsigned DMod     = D % M;
  localparam logic [IdxWidth-1:0] DStep = IdxWidth'(DMod);
  localparam logic [IdxWidth-1:0] KLast = IdxWidth'(M - 1);
  localparam real Pi = 3.14159265358979323846;

  // Round half away from zero, then saturate to the signed output range.
  function automatic logic [PHASE_WIDTH-1:0] quant(input real x);
    real    scaled;
    real    r;
    longint q;
    longint hi;
    longint lo;
    hi     = (longint'(1) <<< (PHASE_WIDTH - 1)) - 1;
    lo     = -(longint'(1) <<< (PHASE_WIDTH - 1));
    scaled = x * (2.0 ** real'(PHASE_FRAC_WIDTH));
    if (scaled >= 0.0) r = $floor(scaled + 0.5);
    else               r = -$floor(-scaled + 0.5);
    q = longint'(r);
    if (q > hi)      q = hi;
    else if (q < lo) q = lo;
    return q[PHASE_WIDTH-1:0];
  endfunction

  // Constant ROM: cos and -sin so that bi is the imaginary part of exp(-j*theta).
  logic [PHASE_WIDTH-1:0] cos_rom [M];
  logic [PHASE_WIDTH-1:0] sin_rom [M];

  for (genvar g = 0; g < M; g++) begin : g_rom
    assign cos_rom[g] = quant($cos(2.0 * Pi * real'(g) / real'(M)));
    assign sin_rom[g] = quant(-$sin(2.0 * Pi * real'(g) / real'(M)));
  end

  // Phase counters
  logic [IdxWidth-1:0] k_q, k_d;
  logic [IdxWidth-1:0] s_q, s_d;
  logic [IdxWidth-1:0] idx_q, idx_d;

  // Stage 1
  logic                   v1_q;
  logic                   last1_q;
  logic [IdxWidth-1:0]    idx1_q;
  logic [PHASE_WIDTH-1:0] cos1_q;
  logic [PHASE_WIDTH-1:0] sin1_q;

  // Stage 2 (outputs)
  logic                   vld_out_q;
  logic                   last_out_q;
  logic [IdxWidth-1:0]    idx_out_q;
  logic [PHASE_WIDTH-1:0] br_q;
  logic [PHASE_WIDTH-1:0] bi_q;

  logic k_at_last;
  assign k_at_last = (k_q == KLast);

  // idx steps by s within a frame; at the frame end s advances by D (mod M)
  // and the next frame starts again from phase 0.
  always_comb begin
    k_d   = k_q;
    s_d   = s_q;
    idx_d = idx_q;
    if (bus.vld_in) begin
      if (k_at_last) begin
        k_d   = '0;
        idx_d = '0;
        s_d   = s_q + DStep;
      end else begin
        k_d   = k_q + IdxWidth'(1);
        idx_d = idx_q + s_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      s_q        <= '0;
      idx_q      <= '0;
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      idx1_q     <= '0;
      cos1_q     <= '0;
      sin1_q     <= '0;
      vld_out_q  <= 1'b0;
      last_out_q <= 1'b0;
      idx_out_q  <= '0;
      br_q       <= '0;
      bi_q       <= '0;
    end else begin
      k_q   <= k_d;
      s_q   <= s_d;
      idx_q <= idx_d;

      v1_q    <= bus.vld_in;
      last1_q <= bus.vld_in & k_at_last;
      if (bus.vld_in) begin
        idx1_q <= idx_q;
        cos1_q <= cos_rom[idx_q];
        sin1_q <= sin_rom[idx_q];
      end

      vld_out_q  <= v1_q;
      last_out_q <= last1_q;
      // Data holds across gaps; only the strobes follow every cycle.
      if (v1_q) begin
        idx_out_q <= idx1_q;
        br_q      <= cos1_q;
        bi_q      <= sin1_q;
      end
    end
  end

  assign bus.vld_out  = vld_out_q;
  assign bus.last_out = last_out_q;
  assign bus.idx_out  = idx_out_q;
  assign bus.br       = br_q;
  assign bus.bi       = bi_q;

endmodule

// File: tb/tb_alpaca_phasor_gen.sv
module tb_alpaca_phasor_gen;

  localparam int M  = 8;
  localparam int D  = 6;
  localparam int W  = 16;
  localparam int F  = 15;
  localparam int IW = 3;
  localparam real Pi = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alpaca_phasor_gen_if #(.M(M), .PHASE_WIDTH(W)) vif ();

  alpaca_phasor_gen #(
    .M(M),
    .D(D),
    .PHASE_WIDTH(W),
    .PHASE_FRAC_WIDTH(F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: samples accepted since reset and a one-deep
  // in-flight slot; outputs appear one edge after they leave the slot.
  int            cnt;
  bit            p1_v;
  bit            p1_last;
  logic [IW-1:0] p1_idx;
  logic          exp_vld;
  logic          exp_last;
  logic [IW-1:0] exp_idx;
  logic [W-1:0]  exp_br;
  logic [W-1:0]  exp_bi;

  // Expected idx sequence for 4 frames of a continuous stream (M=8, D=6).
  int idx_tab [32] = '{0, 0, 0, 0, 0, 0, 0, 0,
                       0, 6, 4, 2, 0, 6, 4, 2,
                       0, 4, 0, 4, 0, 4, 0, 4,
                       0, 2, 4, 6, 0, 2, 4, 6};
  // Known ROM words for the even indices 0,2,4,6.
  int rom_br [4] = '{32767, 0, -32768, 0};
  int rom_bi [4] = '{0, -32768, 0, 32767};

  function automatic int q_ref(input real x);
    real sc;
    real r;
    sc = x * (2.0 ** F);
    if (sc >= 0.0) r = $floor(sc + 0.5);
    else           r = -$floor(-sc + 0.5);
    if (r > 32767.0)  r = 32767.0;
    if (r < -32768.0) r = -32768.0;
    return $rtoi(r);
  endfunction

  function automatic logic [IW-1:0] ref_idx(input int c);
    int n;
    int k;
    n = c / M;
    k = c % M;
    return IW'((k * n * D) % M);
  endfunction

  function automatic logic [W-1:0] ref_cos(input logic [IW-1:0] i);
    return W'(q_ref($cos(2.0 * Pi * real'(i) / real'(M))));
  endfunction

  function automatic logic [W-1:0] ref_sin(input logic [IW-1:0] i);
    return W'(q_ref(-$sin(2.0 * Pi * real'(i) / real'(M))));
  endfunction

  // Drive one cycle, advance the model across the edge, sample 1 time unit later.
  task automatic cycle(input bit v, input bit r);
    vif.vld_in = v;
    rst        = r;
    @(posedge clk);
    if (r) begin
      cnt      = 0;
      p1_v     = 1'b0;
      exp_vld  = 1'b0;
      exp_last = 1'b0;
      exp_idx  = '0;
      exp_br   = '0;
      exp_bi   = '0;
    end else begin
      exp_vld  = p1_v;
      exp_last = p1_v & p1_last;
      if (p1_v) begin
        exp_idx = p1_idx;
        exp_br  = ref_cos(p1_idx);
        exp_bi  = ref_sin(p1_idx);
      end
      p1_v = v;
      if (v) begin
        p1_idx  = ref_idx(cnt);
        p1_last = (cnt % M) == M - 1;
        cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      cycle(i < 3, i < 3);
      tests++;
      if (vif.vld_out !== 1'b0 || vif.br !== '0 || vif.bi !== '0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: vld=%b br=%h bi=%h, required vld=0 br=0 bi=0",
                 i, vif.vld_out, vif.br, vif.bi);
      end
    end
    cycle(1'b1, 1'b0);
    tests++;
    if (vif.vld_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_lat1: vld_out=%b, required 0", vif.vld_out);
    end
    cycle(1'b0, 1'b0);
    tests++;
    if (vif.vld_out !== 1'b1 || vif.idx_out !== 3'd0 || vif.br !== 16'h7fff) begin
      fails++;
      $display("FAIL reset_lat2: vld=%b idx=%0d br=%h, required vld=1 idx=0 br=7fff",
               vif.vld_out, vif.idx_out, vif.br);
    end
    cycle(1'b0, 1'b0);
    tests++;
    if (vif.vld_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_lat3: vld_out=%b, required 0", vif.vld_out);
    end
  endtask

  task automatic test_continuous;
    int nout = 0;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 34; i++) begin
      cycle(i < 32, 1'b0);
      tests++;
      if ({vif.vld_out, vif.last_out, vif.idx_out, vif.br, vif.bi} !==
          {exp_vld, exp_last, exp_idx, exp_br, exp_bi}) begin
        fails++;
        $display("FAIL cont_model cyc%0d: got %b/%b/%0d/%h/%h required %b/%b/%0d/%h/%h", i,
                 vif.vld_out, vif.last_out, vif.idx_out, vif.br, vif.bi,
                 exp_vld, exp_last, exp_idx, exp_br, exp_bi);
      end
      if (vif.vld_out === 1'b1 && nout < 32) begin
        tests++;
        if (int'(vif.idx_out) != idx_tab[nout] || vif.last_out !== ((nout % M) == M - 1)) begin
          fails++;
          $display("FAIL cont_seq out%0d: idx=%0d last=%b, required idx=%0d last=%b", nout,
                   vif.idx_out, vif.last_out, idx_tab[nout], (nout % M) == M - 1);
        end
        nout++;
      end
    end
    tests++;
    if (nout != 32) begin
      fails++;
      $display("FAIL cont_count: %0d outputs, required 32", nout);
    end
  endtask

  task automatic test_rom;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 34; i++) begin
      cycle(i < 32, 1'b0);
      if (vif.vld_out === 1'b1) begin
        tests++;
        if ($signed(vif.br) != rom_br[vif.idx_out >> 1] ||
            $signed(vif.bi) != rom_bi[vif.idx_out >> 1]) begin
          fails++;
          $display("FAIL rom idx%0d: br=%0d bi=%0d, required br=%0d bi=%0d", vif.idx_out,
                   $signed(vif.br), $signed(vif.bi), rom_br[vif.idx_out >> 1],
                   rom_bi[vif.idx_out >> 1]);
        end
      end
    end
  endtask

  task automatic test_gapped;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int nout = 0;
    int sent = 0;
    bit v;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 200 && (sent < 16 || nout < 16); i++) begin
      v = (sent < 16) && ((i < 7) ? pat[i] : ($urandom_range(0, 2) != 0));
      if (v) sent++;
      cycle(v, 1'b0);
      tests++;
      if ({vif.vld_out, vif.last_out, vif.idx_out, vif.br, vif.bi} !==
          {exp_vld, exp_last, exp_idx, exp_br, exp_bi}) begin
        fails++;
        $display("FAIL gap_model cyc%0d: got %b/%b/%0d/%h/%h required %b/%b/%0d/%h/%h", i,
                 vif.vld_out, vif.last_out, vif.idx_out, vif.br, vif.bi,
                 exp_vld, exp_last, exp_idx, exp_br, exp_bi);
      end
      if (vif.vld_out === 1'b1 && nout < 16) begin
        tests++;
        if (int'(vif.idx_out) != idx_tab[nout]) begin
          fails++;
          $display("FAIL gap_seq out%0d: idx=%0d, required %0d", nout, vif.idx_out,
                   idx_tab[nout]);
        end
        nout++;
      end
    end
    tests++;
    if (nout != 16) begin
      fails++;
      $display("FAIL gap_count: %0d outputs, required 16", nout);
    end
  endtask

  task automatic test_midframe_reset;
    int nout = 0;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0);
    // Next sample would be k=5 of frame 1; reset wins over vld_in.
    for (int i = 0; i < 3; i++) begin
      cycle(i == 0, i == 0);
      tests++;
      if (vif.vld_out !== 1'b0) begin
        fails++;
        $display("FAIL midrst_drop cyc%0d: vld_out=%b, required 0", i, vif.vld_out);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(i < 8, 1'b0);
      if (vif.vld_out === 1'b1) begin
        nout++;
        tests++;
        if (vif.idx_out !== 3'd0 || vif.last_out !== (nout == 8)) begin
          fails++;
          $display("FAIL midrst_frame0 out%0d: idx=%0d last=%b, required idx=0 last=%b",
                   nout, vif.idx_out, vif.last_out, nout == 8);
        end
      end
    end
    tests++;
    if (nout != 8) begin
      fails++;
      $display("FAIL midrst_count: %0d outputs, required 8", nout);
    end
  endtask

  task automatic test_wrap;
    logic [IW-1:0] got [40];
    int nout = 0;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 42; i++) begin
      cycle(i < 40, 1'b0);
      if (vif.vld_out === 1'b1 && nout < 40) begin
        got[nout] = vif.idx_out;
        nout++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (nout != 40 || got[32 + i] !== ref_idx(i) || got[24 + i] !== ref_idx(24 + i)) begin
        fails++;
        $display("FAIL wrap k%0d: frame4=%0d frame3=%0d, required %0d and %0d", i,
                 got[32 + i], got[24 + i], ref_idx(i), ref_idx(24 + i));
      end
    end
  endtask

  task automatic test_random;
    bit v;
    bit r;
    for (int i = 0; i < 400; i++) begin
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 63) == 0;
      cycle(v, r);
      tests++;
      if ({vif.vld_out, vif.last_out, vif.idx_out, vif.br, vif.bi} !==
          {exp_vld, exp_last, exp_idx, exp_br, exp_bi}) begin
        fails++;
        $display("FAIL rand_model cyc%0d: got %b/%b/%0d/%h/%h required %b/%b/%0d/%h/%h", i,
                 vif.vld_out, vif.last_out, vif.idx_out, vif.br, vif.bi,
                 exp_vld, exp_last, exp_idx, exp_br, exp_bi);
      end
    end
  endtask

  initial begin
    vif.vld_in = 1'b0;
    rst        = 1'b1;
    test_reset();
    test_continuous();
    test_rom();
    test_gapped();
    test_midframe_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
